// File: rtl/packet_buffer_reader_pkg.sv
// Shared constants for the packet buffer stream stages. This package holds the byte width,
// the buffer geometry, the FSM state encodings and a constant clog2 helper.
package packet_buffer_reader_pkg;

  localparam int unsigned BYTE_LEN                   = 8;
  localparam int unsigned PACKET_BUFFER_SIZE         = 256;
  localparam int unsigned PACKET_BUFFER_READ_LATENCY = 2;

  typedef logic [1:0] pbr_state_t;

  localparam pbr_state_t PBR_IDLE  = 2'd0;
  localparam pbr_state_t PBR_READ  = 2'd1;
  localparam pbr_state_t PBR_DRAIN = 2'd2;
  localparam pbr_state_t PBR_DONE  = 2'd3;

  // Returns at least 1 so that widths derived from it are never zero.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/packet_reader_fifo.sv
// First-word-fall-through FIFO built from registers. The head entry appears on dout_o
// together with valid_o. A byte written in one cycle becomes visible in the next cycle.
// A write and a pop in the same cycle leave the count unchanged.
module packet_reader_fifo
  import packet_buffer_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = BYTE_LEN
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        we_i,
  input  logic [WIDTH-1:0]            din_i,
  input  logic                        re_i,
  output logic [WIDTH-1:0]            dout_o,
  output logic                        valid_o,
  output logic [clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam int unsigned CntW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push;
  logic             pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop  = re_i & (count_q != '0);
  // A full FIFO still accepts a write when it pops in the same cycle.
  assign push = we_i & ((count_q != CntW'(DEPTH)) | pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/packet_buffer_reader.sv
// Streams a byte range out of the packet buffer RAM to a downstream consumer. A credit-limited
// skid FIFO absorbs the RAM read latency, so backpressure never loses data. The address wraps
// modulo RAM_SIZE, which makes the buffer behave as a ring.
// Optional feature: define PACKET_READER_ABORT_EN to add an abort_i input. When it is asserted,
// the current request stops and any in-flight data is discarded.
module packet_buffer_reader
  import packet_buffer_reader_pkg::*;
#(
  parameter int unsigned RAM_SIZE     = PACKET_BUFFER_SIZE,
  parameter int unsigned READ_LATENCY = PACKET_BUFFER_READ_LATENCY,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [clog2(RAM_SIZE)-1:0]  start_addr_i,
  input  logic [clog2(RAM_SIZE):0]    len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        readclk_o,
  output logic [clog2(RAM_SIZE)-1:0]  raddr_o,
  input  logic                        ram_outclk_i,
  input  logic [BYTE_LEN-1:0]         ram_out_i,
  output logic                        outclk_o,
  output logic [BYTE_LEN-1:0]         out_o,
  output logic                        out_last_o,
`ifdef PACKET_READER_ABORT_EN
  input  logic                        abort_i,
`endif
  input  logic                        out_rdy_i
);

  localparam int unsigned AW   = clog2(RAM_SIZE);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned CntW = clog2(FIFO_DEPTH + 1);
  localparam int unsigned InfW = clog2(FIFO_DEPTH + READ_LATENCY + 1);

  pbr_state_t      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            readclk_q, readclk_d;
  logic [LW-1:0]   remaining_q, remaining_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   delivered_q, delivered_d;
  logic [InfW-1:0] inflight_q, inflight_d;
  logic            aborting_q, aborting_d;

  logic [CntW-1:0] fifo_count;
  logic            fifo_valid;
  logic            fifo_we;
  logic            fifo_re;
  logic            ram_accept;
  logic            xfer;
  logic            last_byte;
  logic            abort_req;
  logic            credit_ok;
  int unsigned     outstanding;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(RAM_SIZE - 1)) ? '0 : a + 1'b1;
  endfunction

`ifdef PACKET_READER_ABORT_EN
  assign abort_req = abort_i & ((state_q == PBR_READ) | (state_q == PBR_DRAIN));
`else
  assign abort_req = 1'b0;
`endif

  // Data that arrives with nothing in flight is stale (for example, issued before a reset) and is dropped.
  assign ram_accept = ram_outclk_i & (inflight_q != '0);
  assign fifo_we    = ram_accept & ~aborting_q & ~abort_req;
  assign outclk_o   = fifo_valid & ~aborting_q;
  assign xfer       = outclk_o & out_rdy_i;
  assign fifo_re    = aborting_q ? fifo_valid : xfer;
  assign last_byte  = ((delivered_q + LW'(1)) == len_q);
  assign out_last_o = outclk_o & last_byte;

  // Count every byte already promised to the FIFO: in flight, being strobed, or already stored.
  // A pop in this cycle frees one slot, which sustains 1 byte/cycle.
  assign outstanding = 32'(inflight_q) + 32'(readclk_q) + 32'(fifo_count) - 32'(fifo_re);
  assign credit_ok   = (outstanding < FIFO_DEPTH);

  // Track reads issued to the driver that have not yet returned.
  always_comb begin
    inflight_d = inflight_q;
    if (readclk_q && !ram_accept) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!readclk_q && ram_accept) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  // Request FSM and read-issue logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    raddr_d     = raddr_q;
    readclk_d   = 1'b0;
    remaining_d = remaining_q;
    len_d       = len_q;
    aborting_d  = aborting_q;
    delivered_d = xfer ? delivered_q + LW'(1) : delivered_q;
    case (state_q)
      PBR_IDLE: begin
        delivered_d = '0;
        if (start_i) begin
          len_d = len_i;
          if (len_i == '0) begin
            state_d = PBR_DONE;
          end else begin
            // Issue the first read right away so readclk rises the cycle after start.
            readclk_d   = 1'b1;
            raddr_d     = start_addr_i;
            addr_d      = next_addr(start_addr_i);
            remaining_d = len_i - LW'(1);
            state_d     = (len_i == LW'(1)) ? PBR_DRAIN : PBR_READ;
          end
        end
      end
      PBR_READ: begin
        if (abort_req) begin
          state_d    = PBR_DRAIN;
          aborting_d = 1'b1;
        end else if (credit_ok) begin
          readclk_d   = 1'b1;
          raddr_d     = addr_q;
          addr_d      = next_addr(addr_q);
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) begin
            state_d = PBR_DRAIN;
          end
        end
      end
      PBR_DRAIN: begin
        if (abort_req) begin
          aborting_d = 1'b1;
        end
        if (aborting_q) begin
          if ((inflight_q == '0) && !readclk_q && (fifo_count == '0)) begin
            state_d = PBR_DONE;
          end
        end else if (xfer && last_byte) begin
          state_d = PBR_DONE;
        end
      end
      PBR_DONE: begin
        state_d    = PBR_IDLE;
        aborting_d = 1'b0;
      end
      default: state_d = PBR_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= PBR_IDLE;
      addr_q      <= '0;
      raddr_q     <= '0;
      readclk_q   <= 1'b0;
      remaining_q <= '0;
      len_q       <= '0;
      delivered_q <= '0;
      inflight_q  <= '0;
      aborting_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      raddr_q     <= raddr_d;
      readclk_q   <= readclk_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      aborting_q  <= aborting_d;
    end
  end

  packet_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_LEN)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (fifo_we),
    .din_i   (ram_out_i),
    .re_i    (fifo_re),
    .dout_o  (out_o),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign busy_o    = (state_q != PBR_IDLE);
  assign done_o    = (state_q == PBR_DONE);
  assign readclk_o = readclk_q;
  assign raddr_o   = raddr_q;

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Scoreboard bench for packet_buffer_reader. The packet buffer RAM is modelled as a fixed-latency
// pipeline over mem[i] = i[7:0]. When a request is issued, the expected bytes and read addresses
// are pushed into queues; a negedge monitor pops and compares them.
module tb_packet_buffer_reader;
  import packet_buffer_reader_pkg::*;

  localparam int unsigned RamSize = PACKET_BUFFER_SIZE;
  localparam int unsigned Lat     = PACKET_BUFFER_READ_LATENCY;
  localparam int unsigned Depth   = 4;
  localparam int unsigned AW      = clog2(RamSize);
  localparam int unsigned LW      = AW + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          abort_i = 1'b0;
  logic          out_rdy_i = 1'b1;
  logic          busy_o, done_o, readclk_o, ram_outclk_i, outclk_o, out_last_o;
  logic [AW-1:0] raddr_o;
  logic [7:0]    ram_out_i, out_o;

  int rdy_mode = 0;
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];

  packet_buffer_reader #(
    .RAM_SIZE     (RamSize),
    .READ_LATENCY (Lat),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .readclk_o    (readclk_o),
    .raddr_o      (raddr_o),
    .ram_outclk_i (ram_outclk_i),
    .ram_out_i    (ram_out_i),
    .outclk_o     (outclk_o),
    .out_o        (out_o),
    .out_last_o   (out_last_o),
`ifdef PACKET_READER_ABORT_EN
    .abort_i      (abort_i),
`endif
    .out_rdy_i    (out_rdy_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM driver model: a strobe in cycle t returns mem[addr] with ram_outclk in cycle t+Lat.
  // The model is not reset, so reads already in flight still return after a DUT reset.
  logic          p_v [1:Lat] = '{default: 1'b0};
  logic [AW-1:0] p_a [1:Lat] = '{default: '0};
  always @(posedge clk) begin
    p_v[1] <= readclk_o;
    p_a[1] <= raddr_o;
    for (int k = 2; k <= Lat; k++) begin
      p_v[k] <= p_v[k-1];
      p_a[k] <= p_a[k-1];
    end
  end
  assign ram_outclk_i = p_v[Lat];
  assign ram_out_i    = 8'(p_a[Lat]);

  // Downstream ready pattern.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_rdy_i = 1'b1;
      1:       out_rdy_i = ~out_rdy_i;
      default: out_rdy_i = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  int   issued = 0, xfers = 0, first_rd = -1, first_out = -1, start_cyc = 0, req_len = 0;
  int   abort_cyc = 0, busy_cnt = 0;
  bit   timed = 0, aborted = 0, last_seen = 0, stall_prev = 0, done_prev = 0;
  logic [7:0] prev_out = '0;
  logic       prev_last = 1'b0;
  exp_t       e;
  logic [AW-1:0] a;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_readclk", int'(readclk_o), 0);
      check("rst_outclk", int'(outclk_o), 0);
      check("rst_out_last", int'(out_last_o), 0);
      check("rst_raddr", int'(raddr_o), 0);
      check("rst_out", int'(out_o), 0);
      exp_q.delete();
      addr_q.delete();
      stall_prev = 0;
      done_prev  = 0;
      busy_cnt   = 0;
    end else begin
      if (start_i && !busy_o) begin
        issued = 0; xfers = 0; first_rd = -1; first_out = -1;
        start_cyc = cyc; req_len = int'(len_i); timed = (rdy_mode == 0);
        aborted = 0; last_seen = 0;
      end
      if (abort_i && busy_o && !done_o && !aborted) begin
        aborted = 1;
        abort_cyc = cyc;
      end
      if (stall_prev && !aborted) begin
        check("stall_hold_valid", int'(outclk_o), 1);
        check("stall_hold_data", int'(out_o), int'(prev_out));
        check("stall_hold_last", int'(out_last_o), int'(prev_last));
      end
      if (readclk_o) begin
        issued++;
        if (first_rd < 0) first_rd = cyc;
        if (aborted && cyc > abort_cyc) check("read_after_abort", 1, 0);
        else if (addr_q.size() == 0) check("unexpected_read", int'(raddr_o), -1);
        else begin
          a = addr_q.pop_front();
          check("raddr", int'(raddr_o), int'(a));
        end
      end
      if (busy_o) check("occupancy_le_depth", int'((issued - xfers) <= int'(Depth)), 1);
      if (outclk_o && first_out < 0) first_out = cyc;
      if (aborted && cyc > abort_cyc && outclk_o) begin
        check("outclk_after_abort", 1, 0);
      end else if (outclk_o && out_rdy_i) begin
        xfers++;
        if (out_last_o) last_seen = 1;
        if (exp_q.size() == 0) check("unexpected_byte", int'(out_o), -1);
        else begin
          e = exp_q.pop_front();
          check("out_data", int'(out_o), int'(e.data));
          check("out_last", int'(out_last_o), int'(e.last));
        end
      end
      if (done_o) begin
        check("done_pulse_width", int'(done_prev), 0);
        if (aborted) begin
          check("abort_no_last", int'(last_seen), 0);
          exp_q.delete();
          addr_q.delete();
        end else begin
          check("bytes_remaining", exp_q.size(), 0);
          check("reads_remaining", addr_q.size(), 0);
          if (timed && req_len == 0) begin
            check("len0_no_read", first_rd, -1);
            check("len0_done_cycle", cyc, start_cyc + 1);
          end else if (timed) begin
            check("first_read_cycle", first_rd, start_cyc + 1);
            check("first_out_cycle", first_out, start_cyc + 2 + int'(Lat));
            check("done_cycle", cyc, start_cyc + 2 + int'(Lat) + req_len);
          end
        end
      end
      busy_cnt = busy_o ? busy_cnt + 1 : 0;
      if (busy_cnt == 3000) check("watchdog_busy", busy_cnt, 0);
      stall_prev = outclk_o && !out_rdy_i;
      prev_out   = out_o;
      prev_last  = out_last_o;
      done_prev  = done_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int unsigned addr, input int unsigned len, input bit push);
    start_i      = 1'b1;
    start_addr_i = AW'(addr);
    len_i        = LW'(len);
    if (push) begin
      for (int unsigned i = 0; i < len; i++) begin
        exp_q.push_back('{data: 8'((addr + i) % RamSize), last: (i == len - 1)});
        addr_q.push_back(AW'((addr + i) % RamSize));
      end
    end
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      if (done_o) break;
      tick();
    end
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    issue(10, 5, 1);                       // basic latency and ordering
    wait_done();
    issue(RamSize - 2, 4, 1);              // address wraps to 0
    wait_done();

    rdy_mode = 1;                          // backpressure on alternate cycles
    tick();
    issue(30, 64, 1);
    wait_done();
    rdy_mode = 0;
    repeat (2) tick();

    issue(77, 0, 1);                       // zero length request
    wait_done();
    issue(20, 6, 1);
    tick();
    issue(200, 5, 0);                      // arrives while busy; must be ignored
    wait_done();
    repeat (10) tick();

    issue(40, 20, 1);                      // reset with two reads in flight
    for (int i = 0; i < 50; i++) begin
      if (p_v[1] && p_v[2]) break;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    issue(5, 3, 1);
    wait_done();

`ifdef PACKET_READER_ABORT_EN
    issue(100, 10, 1);
    for (int i = 0; i < 100; i++) begin
      if (xfers >= 3) break;
      tick();
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    wait_done();
    repeat (3) tick();
    issue(50, 4, 1);
    wait_done();
`endif

    repeat (8) begin
      rdy_mode = int'($urandom_range(0, 2));
      tick();
      issue($urandom_range(0, RamSize - 1), $urandom_range(0, 40), 1);
      wait_done();
    end
    repeat (5) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
